// File: rtl/serial_word_rx.sv
// serial_word_rx
//   Serial-to-parallel receiver for an MSB-first bit stream. Each word is
//   framed by sfirst_i on its first bit and is W bits long. A finished word
//   goes into a one-word holding register that is read over a valid/ready
//   port. Framing errors and overruns raise sticky flags.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous active-high reset
//   clr_i      synchronous clear with the same effect as rst
//   sdata_i    serial data bit, MSB first
//   sval_i     sdata_i is valid this cycle
//   sfirst_i   marks the first bit of a word (used only when sval_i=1)
//   dout_o     received word; stable while dvalid_o=1
//   dvalid_o   dout_o holds an unconsumed word
//   dready_i   consumer accepts dout_o when dvalid_o && dready_i
//   busy_o     a word is partly received
//   ferr_o     sticky framing-error flag
//   ovr_o      sticky overrun flag
module serial_word_rx #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         sdata_i,
   input  logic         sval_i,
   input  logic         sfirst_i,
   output logic [W-1:0] dout_o,
   output logic         dvalid_o,
   input  logic         dready_i,
   output logic         busy_o,
   output logic         ferr_o,
   output logic         ovr_o
);

   localparam int CW = (W > 2) ? $clog2(W) : 1;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   logic [0:0]    state_q, state_d;
   logic [W-1:0]  sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  dout_q, dout_d;
   logic          dvalid_q, dvalid_d;
   logic          ferr_q, ferr_d;
   logic          ovr_q, ovr_d;

   logic          complete;
   logic [W-1:0]  sr_shifted;

   assign sr_shifted = {sr_q[W-2:0], sdata_i};

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      dvalid_d = dvalid_q;
      ferr_d   = ferr_q;
      ovr_d    = ovr_q;
      complete = 1'b0;

      // Bit handling
      if (sval_i) begin
         if (state_q == IDLE) begin
            // A bit without sfirst in IDLE is a stray and is dropped.
            if (sfirst_i) begin
               sr_d    = sr_shifted;
               cnt_d   = CNT_ONE;
               state_d = SHIFT;
            end
         end else if (sfirst_i) begin
            // Early sfirst: drop the partial word and restart on this bit.
            // The stale bits in sr are shifted out before the next word
            // can complete, so sr does not need clearing.
            ferr_d = 1'b1;
            sr_d   = sr_shifted;
            cnt_d  = CNT_ONE;
         end else begin
            sr_d = sr_shifted;
            if (cnt_q == CNT_LAST) begin
               complete = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
      end

      // Output register. A transfer in the same cycle frees the slot for
      // the word that completes in that cycle.
      if (complete) begin
         if (!dvalid_q || dready_i) begin
            dout_d   = sr_shifted;
            dvalid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (dvalid_q && dready_i) begin
         dvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sr_q     <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else if (clr_i) begin
         state_q  <= IDLE;
         sr_q     <= '0;
         cnt_q    <= '0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
      end
   end

   assign dout_o   = dout_q;
   assign dvalid_o = dvalid_q;
   assign busy_o   = (state_q == SHIFT);
   assign ferr_o   = ferr_q;
   assign ovr_o    = ovr_q;

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel receiver for the MSB-first shift-left stream produced by our loadable shift registers. It collects `w` framed serial bits into a word and presents the word on a valid/ready output port with a one-word holding register. It sits at the receive end of the serial link, between the bit stream and the word-level consumer. It flags framing errors and overruns.

## Interface
- `w`, default 8, word width in bits; legal range `w >= 2`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `clr`  in  1  synchronous clear; same effect as `rst`, taken at the clock edge.
- `sdata`  in  1  serial data bit, MSB first.
- `sval`  in  1  `sdata` is valid this cycle; bits with `sval=0` are ignored.
- `sfirst`  in  1  qualifies the first bit of a word; meaningful only when `sval=1`.
- `dout`  out  w  received word; stable while `dvalid=1`.
- `dvalid`  out  1  `dout` holds an unconsumed word.
- `dready`  in  1  consumer accepts `dout`; a transfer happens when `dvalid && dready`.
- `busy`  out  1  a word is partially received (state is SHIFT).
- `ferr`  out  1  sticky framing-error flag.
- `ovr`  out  1  sticky overrun flag.

## Operation
- Internal state:
  - shift register `sr[w-1:0]`;
  - bit counter `cnt`, range 0..w-1, width `$clog2(w)`;
  - FSM with two states, IDLE and SHIFT;
  - output register `dout`/`dvalid`.
- Accepting a bit: `sr <= {sr[w-2:0], sdata}`.
- IDLE:
  - `sval && sfirst`: accept the bit, set `cnt=1`, go to SHIFT.
  - `sval && !sfirst`: the stray bit is dropped silently. No flag is set.
- SHIFT, `sval && !sfirst`: accept the bit and increment `cnt`.
  - When the accepted bit is bit `w` (`cnt == w-1`), the word is complete.
  - Complete word = `{sr[w-2:0], sdata}`. `cnt` returns to 0 and the FSM goes to IDLE.
- SHIFT, `sval && sfirst`: set `ferr`.
  - Discard the partial word.
  - Treat this bit as bit 1 of a new word: `cnt=1`, stay in SHIFT.
- Word completion versus the output register:
  - `dvalid=0`, or `dvalid && dready` in the same cycle: load `dout`, and `dvalid=1`.
  - `dvalid && !dready`: the new word is dropped, `ovr` is set, and `dout` is unchanged.
- Output transfer with no completion in the same cycle: `dvalid && dready` clears `dvalid`.
- `ferr` and `ovr` clear only on `rst` or `clr`.
- `busy = (state == SHIFT)`.
- Priority, highest first: `rst`, then `clr`, then bit handling and output transfer.
  - Bit handling and output transfer are evaluated together in the same cycle.

## Timing
- Reset values (on `rst`, or at the edge where `clr` is sampled):
  - `dout = '0`, `dvalid = 0`, `busy = 0`, `ferr = 0`, `ovr = 0`;
  - `sr = '0`, `cnt = 0`, state IDLE.
- Latency: last bit sampled at edge N gives `dvalid=1` with the new `dout` after edge N.
  - The consumer sees the word in cycle N+1.
- Throughput: one bit per cycle, sustained.
  - Back-to-back words with `sfirst` on the bit right after the last bit need no idle cycle.
- `dvalid` never drops without a transfer; `dout` never changes while `dvalid && !dready`.
- Reset mid-word: `rst` or `clr` abandons the partial word.
  - The next word must start with `sfirst`.
  - A `sfirst` bit in the same cycle as `clr` is ignored.
- `sfirst` on the final expected bit (`cnt == w-1`) is a framing error. No word is output.
- `w=2` is legal: the FSM enters SHIFT after bit 1 and completes on bit 2.

## Test plan
All scenarios use `w=8`.
- Basic receive:
  - Stimulus: send `0xA5` MSB first (`sfirst` on bit 1, `sval=1` for 8 cycles), `dready=1`.
  - Response: `dout=0xA5`, `dvalid=1` for exactly one cycle, starting the cycle after bit 8; `busy` high during bits 2–8.
- Gapped bits and back-to-back words:
  - Stimulus: send `0x3C` with `sval` low every other cycle, then `0xC3` immediately after with no gap.
  - Response: `dout=0x3C`, then `0xC3`; no flags set.
- Overrun:
  - Stimulus: `dready=0`; send `0x11`, then `0x22`.
  - Response: `dout` stays `0x11`, `dvalid=1`, `ovr=1`.
  - Then raise `dready` for 1 cycle: `dvalid=0`, and `ovr` stays 1.
- Completion coinciding with transfer:
  - Stimulus: `dvalid=1` holding `0x11`; pulse `dready` in the same cycle that bit 8 of `0x22` arrives.
  - Response: `dout=0x22`, `dvalid=1`, `ovr=0`.
- Framing error:
  - Stimulus: 4 bits of a word, then `sfirst` with `0x5A`.
  - Response: `ferr=1`, and the only output is `dout=0x5A`.
- Stray bits and mid-word reset:
  - Stimulus: `sval` bits without `sfirst` in IDLE.
  - Response: ignored; `busy=0`.
  - Stimulus: assert `rst` after 5 bits.
  - Response: all outputs 0; the next framed `0xFF` is received correctly.
  - Stimulus: repeat with `clr`.
  - Response: identical behaviour.
